// File: rtl/eye_opening_monitor.sv
// Vertical eye-opening monitor: settle, accumulate a window of decisions, publish min(ones) - max(zeros).
// Optional EYE_MON_AVG_EN averages the published opening over the last up to 4 windows.
module eye_opening_monitor #(
    parameter int  WINDOW_SIZE    = 256,
    parameter int  SETTLE_SAMPLES = 64,
    parameter real THRESHOLD      = 0.0
) (
    input  logic clock,
    input  logic reset_n,
    input  real  sample,
    input  logic sample_valid,
    output real  opening,
    output logic opening_ready,
    output logic eye_closed
);

    localparam int CNT_MAX = (WINDOW_SIZE > SETTLE_SAMPLES) ? WINDOW_SIZE : SETTLE_SAMPLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_SIZE - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_SAMPLES - 1);

    typedef enum logic [1:0] {SETTLE, ACCUM, PUBLISH} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    real              min_one, max_zero;
    logic             seen_one, seen_zero;

    // Accumulators as they stand after folding in the current sample, so the
    // result can be registered on the same edge that accepts the last sample.
    real  min_one_nx, max_zero_nx, raw, pub_val;
    logic seen_one_nx, seen_zero_nx;

    always_comb begin
        min_one_nx   = min_one;
        max_zero_nx  = max_zero;
        seen_one_nx  = seen_one;
        seen_zero_nx = seen_zero;
        if (sample >= THRESHOLD) begin
            if (sample < min_one) min_one_nx = sample;
            seen_one_nx = 1'b1;
        end else begin
            if (sample > max_zero) max_zero_nx = sample;
            seen_zero_nx = 1'b1;
        end
        raw = (seen_one_nx && seen_zero_nx) ? (min_one_nx - max_zero_nx) : 0.0;
    end

`ifdef EYE_MON_AVG_EN
    // Three prior results plus the current raw value form the 4-entry average.
    real        hist [3];
    logic [2:0] fill, fill_nx;

    always_comb begin
        fill_nx = (fill == 3'd4) ? 3'd4 : fill + 3'd1;
        pub_val = raw;
        if (fill_nx > 3'd1) pub_val = pub_val + hist[0];
        if (fill_nx > 3'd2) pub_val = pub_val + hist[1];
        if (fill_nx > 3'd3) pub_val = pub_val + hist[2];
        pub_val = pub_val / real'(fill_nx);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fill    <= 3'd0;
            hist[0] <= 0.0;
            hist[1] <= 0.0;
            hist[2] <= 0.0;
        end else if (state == ACCUM && sample_valid && cnt == WIN_LAST) begin
            fill    <= fill_nx;
            hist[0] <= raw;
            hist[1] <= hist[0];
            hist[2] <= hist[1];
        end
    end
`else
    always_comb pub_val = raw;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= SETTLE;
            cnt           <= '0;
            min_one       <= 1.0e30;
            max_zero      <= -1.0e30;
            seen_one      <= 1'b0;
            seen_zero     <= 1'b0;
            opening       <= 0.0;
            opening_ready <= 1'b0;
            eye_closed    <= 1'b1;
        end else begin
            opening_ready <= 1'b0;
            case (state)
                SETTLE: begin
                    if (SETTLE_SAMPLES == 0) begin
                        state <= ACCUM;
                    end else if (sample_valid) begin
                        if (cnt == SET_LAST) begin
                            cnt   <= '0;
                            state <= ACCUM;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (sample_valid) begin
                        min_one   <= min_one_nx;
                        max_zero  <= max_zero_nx;
                        seen_one  <= seen_one_nx;
                        seen_zero <= seen_zero_nx;
                        if (cnt == WIN_LAST) begin
                            cnt           <= '0;
                            state         <= PUBLISH;
                            opening       <= pub_val;
                            eye_closed    <= (pub_val <= 0.0);
                            opening_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PUBLISH: begin
                    min_one   <= 1.0e30;
                    max_zero  <= -1.0e30;
                    seen_one  <= 1'b0;
                    seen_zero <= 1'b0;
                    cnt       <= '0;
                    state     <= SETTLE;
                end
                default: state <= SETTLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eye_opening_monitor.sv
// Bench for eye_opening_monitor (WINDOW_SIZE=4, SETTLE_SAMPLES=2); expected results queued at stimulus time.
module tb_eye_opening_monitor;

    logic clock = 1'b0;
    logic reset_n;
    real  sample;
    logic sample_valid;
    real  opening;
    logic opening_ready;
    logic eye_closed;

    eye_opening_monitor #(.WINDOW_SIZE(4), .SETTLE_SAMPLES(2), .THRESHOLD(0.0)) dut (
        .clock(clock), .reset_n(reset_n), .sample(sample), .sample_valid(sample_valid),
        .opening(opening), .opening_ready(opening_ready), .eye_closed(eye_closed)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { real op; bit closed; int due; } exp_t;
    typedef struct { real s[6]; real op; bit closed; } vec_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk_r(string name, real act, real req);
        n_chk++;
        if ((act - req) < 1.0e-9 && (req - act) < 1.0e-9) n_pass++;
        else $display("FAIL %s: got %f, expected %f", name, act, req);
    endtask

    task automatic chk_i(string name, int act, int req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    // Scoreboard: every strobe must match the oldest queued result, on its due cycle.
    logic prev_rdy = 1'b0;
    always @(negedge clock) begin : mon
        exp_t e;
        if (opening_ready) begin
            chk_i("strobe_not_back_to_back", int'(prev_rdy), 0);
            if (q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_strobe: got strobe at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                chk_r("opening", opening, e.op);
                chk_i("eye_closed", int'(eye_closed), int'(e.closed));
                chk_i("strobe_cycle", cyc, e.due);
            end
        end
        prev_rdy = opening_ready;
    end

    task automatic put(real s, bit v);
        @(negedge clock);
        sample       = s;
        sample_valid = v;
    endtask

    // Called right after the final window sample is driven: strobe due one cycle later.
    task automatic expect_now(real op, bit closed);
        exp_t e;
        e.op = op; e.closed = closed; e.due = cyc + 1;
        q.push_back(e);
    endtask

    task automatic run_vec(vec_t v);
        for (int i = 0; i < 6; i++) put(v.s[i], 1'b1);
        expect_now(v.op, v.closed);
        put(0.0, 1'b0);
    endtask

    task automatic drain(string name);
        for (int i = 0; i < 8 && q.size() != 0; i++) @(negedge clock);
        chk_i(name, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        real  avg_raw[5];
        real  avg_exp[5];

        // settle0, settle1, window0..3 -> expected opening, eye_closed
        tbl[0].s = '{1.0, 1.0, 0.2, 0.3, 0.1, 0.4};     tbl[0].op = 0.0;  tbl[0].closed = 1'b1;
        tbl[1].s = '{5.0, -5.0, 0.4, -0.3, 0.6, -0.5};  tbl[1].op = 0.7;  tbl[1].closed = 1'b0;
        tbl[2].s = '{0.0, 0.0, 0.0, -0.2, 0.5, -0.1};   tbl[2].op = 0.1;  tbl[2].closed = 1'b0;
        tbl[3].s = '{0.0, 0.0, -0.1, -0.2, -0.3, -0.4}; tbl[3].op = 0.0;  tbl[3].closed = 1'b1;
        tbl[4].s = '{9.0, -9.0, 1.5, -1.0, 2.0, -0.25}; tbl[4].op = 1.75; tbl[4].closed = 1'b0;

        avg_raw = '{0.8, 0.4, 0.6, 0.2, 1.0};
        avg_exp = '{0.8, 0.6, 0.6, 0.5, 0.55};

        reset_n      = 1'b0;
        sample       = 0.0;
        sample_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            sample = (i % 2 == 0) ? 3.0 : -3.0;
            chk_r("reset_opening", opening, 0.0);
            chk_i("reset_ready", int'(opening_ready), 0);
            chk_i("reset_eye_closed", int'(eye_closed), 1);
        end
        sample_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;

`ifdef EYE_MON_AVG_EN
        for (int w = 0; w < 5; w++) begin
            v.s = '{3.0, -3.0, avg_raw[w] / 2.0, -avg_raw[w] / 2.0, avg_raw[w] / 2.0, -avg_raw[w] / 2.0};
            v.op = avg_exp[w];
            v.closed = 1'b0;
            run_vec(v);
            drain("avg_drain");
        end
`else
        for (int i = 0; i < 5; i++) begin
            run_vec(tbl[i]);
            drain("table_drain");
        end

        // Invalid cycles carrying large values must not disturb the result.
        put(5.0, 1'b1);  put(9.0, 1'b0);  put(-5.0, 1'b1);
        put(-9.0, 1'b0); put(0.4, 1'b1);  put(9.0, 1'b0);  put(9.0, 1'b0);
        put(-0.3, 1'b1); put(-9.0, 1'b0); put(0.6, 1'b1);  put(9.0, 1'b0);
        put(-0.5, 1'b1);
        expect_now(0.7, 1'b0);
        put(0.0, 1'b0);
        drain("gap_drain");

        // Reset after 3 window samples discards the partial window.
        put(1.0, 1'b1); put(-1.0, 1'b1); put(0.9, 1'b1); put(-0.9, 1'b1); put(0.8, 1'b1);
        @(negedge clock);
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        @(negedge clock);
        chk_r("midreset_opening", opening, 0.0);
        chk_i("midreset_eye_closed", int'(eye_closed), 1);
        reset_n = 1'b1;
        put(-9.0, 1'b1); put(9.0, 1'b1);
        put(0.3, 1'b1);  put(-0.2, 1'b1); put(0.35, 1'b1);
        for (int i = 0; i < 4; i++) put(0.0, 1'b0);
        chk_i("no_early_strobe", q.size(), 0);
        put(-0.25, 1'b1);
        expect_now(0.5, 1'b0);
        put(0.0, 1'b0);
        drain("midreset_drain");
`endif

        // Held values between strobes.
        repeat (3) @(negedge clock);
`ifdef EYE_MON_AVG_EN
        chk_r("hold_opening", opening, 0.55);
`else
        chk_r("hold_opening", opening, 0.5);
`endif
        chk_i("hold_eye_closed", int'(eye_closed), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
